// File: rtl/chain_code_decoder.sv
// chain_code_decoder
//
// Rebuilds a 1-bit boundary image from a Freeman 8-direction chain code stream.
// It clears the whole image RAM, plots the start pixel, and then plots one pixel
// for each code it accepts. It reports the contour length, whether the contour
// closed on the start pixel, and any out-of-bounds start or step.
//
// Ports
//   clk_1                rising-edge system clock
//   reset                asynchronous, active-low reset
//   start                begin decode (sampled only while idle)
//   start_x, start_y     start pixel
//   code_valid/ready     code handshake (ready only in RUN)
//   code, code_last      Freeman direction 0..7, final-code marker
//   mem_we/addr/din      registered image RAM write port, addr = y*IMG_W + x
//   busy, done           decode in progress / one-cycle completion pulse
//   closed, err          end == start / out-of-bounds (held until next start)
//   length               accepted in-bounds codes, saturating
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; start and bounds checks happen here
// CLEAR  | writing 0 to every image address, one per cycle
// PLOT   | writing the start pixel
// RUN    | accepting codes, one pixel write per accepted code
// FIN    | single cycle that raises done and drops busy
module chain_code_decoder #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int XW    = 6,
    parameter int YW    = 6,
    parameter int AW    = 12,
    parameter int LW    = 12
) (
    input  logic          clk_1,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] start_x,
    input  logic [YW-1:0] start_y,
    input  logic          code_valid,
    output logic          code_ready,
    input  logic [2:0]    code,
    input  logic          code_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          mem_din,
    output logic          busy,
    output logic          done,
    output logic          closed,
    output logic          err,
    output logic [LW-1:0] length
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLOT,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [XW:0]   X_LIM     = (XW+1)'(IMG_W);
    localparam logic [YW:0]   Y_LIM     = (YW+1)'(IMG_H);
    localparam logic [AW-1:0] W_AW      = AW'(IMG_W);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    state_t        state, state_nxt;
    logic [XW-1:0] x, x_nxt, sx, sx_nxt;
    logic [YW-1:0] y, y_nxt, sy, sy_nxt;
    logic [AW-1:0] clr_addr, clr_addr_nxt;
    logic          mem_we_nxt, mem_din_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic          busy_nxt, done_nxt, closed_nxt, err_nxt;
    logic [LW-1:0] length_nxt;

    // Candidate next coordinate. The step is done one bit wider than the
    // coordinate so that -1 wraps to a large unsigned value; a single
    // unsigned compare against the image size then catches both edges.
    logic [XW:0]   dx_ext, nx_ext;
    logic [YW:0]   dy_ext, ny_ext;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          step_oob, start_oob;

    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px,
                                               input logic [YW-1:0] py);
        return AW'(py) * W_AW + AW'(px);
    endfunction

    always_comb begin
        dx_ext = '0;
        dy_ext = '0;
        case (code)
            3'd0: begin dx_ext = (XW+1)'(1); dy_ext = '0;         end
            3'd1: begin dx_ext = (XW+1)'(1); dy_ext = '1;         end
            3'd2: begin dx_ext = '0;         dy_ext = '1;         end
            3'd3: begin dx_ext = '1;         dy_ext = '1;         end
            3'd4: begin dx_ext = '1;         dy_ext = '0;         end
            3'd5: begin dx_ext = '1;         dy_ext = (YW+1)'(1); end
            3'd6: begin dx_ext = '0;         dy_ext = (YW+1)'(1); end
            default: begin dx_ext = (XW+1)'(1); dy_ext = (YW+1)'(1); end
        endcase
    end

    assign nx_ext    = {1'b0, x} + dx_ext;
    assign ny_ext    = {1'b0, y} + dy_ext;
    assign nx        = nx_ext[XW-1:0];
    assign ny        = ny_ext[YW-1:0];
    assign step_oob  = (nx_ext >= X_LIM) || (ny_ext >= Y_LIM);
    assign start_oob = ({1'b0, start_x} >= X_LIM) || ({1'b0, start_y} >= Y_LIM);

    assign code_ready = (state == S_RUN);

    always_comb begin
        state_nxt    = state;
        x_nxt        = x;
        y_nxt        = y;
        sx_nxt       = sx;
        sy_nxt       = sy;
        clr_addr_nxt = clr_addr;
        mem_we_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        closed_nxt   = closed;
        err_nxt      = err;
        length_nxt   = length;

        case (state)
            S_IDLE: begin
                if (start) begin
                    sx_nxt       = start_x;
                    sy_nxt       = start_y;
                    x_nxt        = start_x;
                    y_nxt        = start_y;
                    clr_addr_nxt = '0;
                    closed_nxt   = 1'b0;
                    length_nxt   = '0;
                    if (start_oob) begin
                        // Rejected start finishes immediately; busy stays low
                        // so busy never overlaps a done pulse.
                        err_nxt  = 1'b1;
                        done_nxt = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        err_nxt   = 1'b0;
                        busy_nxt  = 1'b1;
                        state_nxt = S_CLEAR;
                    end
                end
            end

            S_CLEAR: begin
                mem_we_nxt   = 1'b1;
                mem_din_nxt  = 1'b0;
                mem_addr_nxt = clr_addr;
                clr_addr_nxt = clr_addr + 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = S_PLOT;
                end
            end

            S_PLOT: begin
                mem_we_nxt   = 1'b1;
                mem_din_nxt  = 1'b1;
                mem_addr_nxt = pix_addr(sx, sy);
                state_nxt    = S_RUN;
            end

            S_RUN: begin
                if (code_valid) begin
                    if (step_oob) begin
                        err_nxt    = 1'b1;
                        closed_nxt = 1'b0;
                        state_nxt  = S_FIN;
                    end else begin
                        mem_we_nxt   = 1'b1;
                        mem_din_nxt  = 1'b1;
                        mem_addr_nxt = pix_addr(nx, ny);
                        x_nxt        = nx;
                        y_nxt        = ny;
                        if (length != '1) begin
                            length_nxt = length + 1'b1;
                        end
                        if (code_last) begin
                            closed_nxt = (nx == sx) && (ny == sy);
                            state_nxt  = S_FIN;
                        end
                    end
                end
            end

            S_FIN: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            sx       <= '0;
            sy       <= '0;
            clr_addr <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            closed   <= 1'b0;
            err      <= 1'b0;
            length   <= '0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            sx       <= sx_nxt;
            sy       <= sy_nxt;
            clr_addr <= clr_addr_nxt;
            mem_we   <= mem_we_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            closed   <= closed_nxt;
            err      <= err_nxt;
            length   <= length_nxt;
        end
    end

endmodule
